// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN             : address / instruction width (fixed at 32 for RV32I)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_BYTES      : PC increment per sequential instruction
//   fetch_bundle_t   : {pc, instr, pc_plus_four} delivered to decode
//   ptr_width()      : index width for a slot queue of a given depth
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int              INSTR_BYTES      = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_four;
    } fetch_bundle_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// Reserve/fill/pop slot storage for outstanding fetches.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : drop every slot and rewind all pointers
//   alloc_en/pc  : reserve the next slot for an accepted request at pc
//   fill_en/instr: write a memory response into the oldest unfilled slot
//   pop_en       : retire the head slot (only when head_filled)
//   head_filled  : head slot holds a returned instruction
//   head         : head slot contents
//   occupancy    : reserved-but-not-popped slots (0..DEPTH)
//   outstanding  : reserved-but-not-filled slots (requests awaiting data)
module fetch_slot_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc_en,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill_en,
    input  logic [XLEN-1:0] fill_instr,
    input  logic            pop_en,
    output logic            head_filled,
    output fetch_bundle_t   head,
    output logic [PW:0]     occupancy,
    output logic [PW:0]     outstanding
);

    // Pointers carry one extra wrap bit so that full (DEPTH) and empty (0)
    // differences stay distinguishable; the low PW bits index the slots.
    logic [PW:0]      alloc_ptr, fill_ptr, rd_ptr;
    fetch_bundle_t    slots [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [DEPTH-1:0] fill_mask, pop_mask;

    logic [PW-1:0] alloc_idx, fill_idx, rd_idx;
    assign alloc_idx = alloc_ptr[PW-1:0];
    assign fill_idx  = fill_ptr[PW-1:0];
    assign rd_idx    = rd_ptr[PW-1:0];

    always_comb begin
        fill_mask = '0;
        pop_mask  = '0;
        if (fill_en) fill_mask[fill_idx] = 1'b1;
        if (pop_en)  pop_mask[rd_idx]    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            slot_filled <= '0;
        end else begin
            if (alloc_en) begin
                // pc + 4 is captured with the slot so an idle head reads back 0
                slots[alloc_idx].pc           <= alloc_pc;
                slots[alloc_idx].pc_plus_four <= alloc_pc + XLEN'(INSTR_BYTES);
                alloc_ptr                     <= alloc_ptr + 1'b1;
            end
            if (fill_en) begin
                slots[fill_idx].instr <= fill_instr;
                fill_ptr              <= fill_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            slot_filled <= (slot_filled & ~pop_mask) | fill_mask;
        end
    end

    assign head_filled = slot_filled[rd_idx];
    assign head        = slots[rd_idx];
    assign occupancy   = alloc_ptr - rd_ptr;
    assign outstanding = alloc_ptr - fill_ptr;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// RV32I instruction-fetch front end with a prefetch slot queue.
//   clk, rst_n          : clock, asynchronous active-low reset
//   redirect_valid/pc   : branch/jump/flush; target bits [1:0] are ignored
//   imem_req_*          : fetch request (valid/ready), word-aligned address
//   imem_rsp_*          : in-order instruction response, never back-pressured
//   out_*               : {pc, instr, pc+4} bundle toward IF/ID (valid/ready)
//
// Handshake rule for both valid/ready ports: a transfer happens in a cycle
// where valid and ready are both high; once raised, valid and its payload
// stay put until that transfer happens (a redirect is the only thing that
// withdraws them).
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc_plus_four
);

    localparam int              PW       = ptr_width(FIFO_DEPTH);
    localparam logic [PW:0]     DEPTH_W  = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW+2:0]   DROP_MAX = (PW+3)'(2 * FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

    logic [XLEN-1:0] fetch_pc;
    logic            req_en;        // holds requests off for the reset cycle
    logic [PW+1:0]   drop_cnt;      // stale responses still owed by memory
    logic [PW+1:0]   drop_next;
    logic            req_fire, out_fire, fill_en;
    logic            head_filled;
    fetch_bundle_t   head;
    logic [PW:0]     occupancy, outstanding;

    assign imem_req_valid = req_en && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid        = head_filled && !redirect_valid;
    assign out_fire         = out_valid && out_ready;
    assign out_pc           = head.pc;
    assign out_instr        = head.instr;
    assign out_pc_plus_four = head.pc_plus_four;

    // A response only lands in the queue once every stale one has drained.
    assign fill_en = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    always_comb begin
        drop_next = drop_cnt;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving
            // now is either the oldest of those or an already-stale one, so
            // either way it reduces the total by one.
            drop_next = drop_cnt + (PW+2)'(outstanding) - (PW+2)'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_next = drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_en   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            req_en   <= 1'b1;
            drop_cnt <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    fetch_slot_queue #(
        .DEPTH (FIFO_DEPTH)
    ) u_slot_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .alloc_en    (req_fire),
        .alloc_pc    (fetch_pc),
        .fill_en     (fill_en),
        .fill_instr  (imem_rsp_instr),
        .pop_en      (out_fire),
        .head_filled (head_filled),
        .head        (head),
        .occupancy   (occupancy),
        .outstanding (outstanding)
    );

    logic [PW+2:0] drop_plus_occ;
    assign drop_plus_occ = (PW+3)'(drop_cnt) + (PW+3)'(occupancy);

    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_plus_occ <= DROP_MAX);

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (drop_cnt == '0) && (outstanding == '0)));

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the RV32I five-stage pipeline.
- Decouples PC generation from a variable-latency instruction memory using a valid/ready request/response port and up to FIFO_DEPTH outstanding fetches.
- Delivers in-order {pc, instr, pc+4} bundles to decode through a valid/ready handshake.
- Branch/jump redirects flush all queued and in-flight fetches; stale memory responses are silently dropped.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- FIFO_DEPTH, 4, slot-queue entries and maximum outstanding fetches; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump taken or flush; highest priority.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  in-order response valid; always accepted, no backpressure.
- imem_rsp_instr  in  XLEN  fetched instruction.
- out_valid  out  1  bundle valid toward IF/ID.
- out_ready  in  1  decode accepts; low = stall.
- out_pc  out  XLEN  instruction PC.
- out_instr  out  XLEN  instruction word.
- out_pc_plus_four  out  XLEN  out_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; all pointers and counters = 0; drop_cnt = 0.
  - imem_req_valid = 0, out_valid = 0, imem_req_addr = RESET_PC; out_pc, out_instr, out_pc_plus_four = 0.
- Slot queue: FIFO_DEPTH entries of {pc, instr, filled}. Three pointers, each of width $clog2(FIFO_DEPTH) with wrap:
  - alloc_ptr: slot reserved when a request is accepted; entry pc = imem_req_addr.
  - fill_ptr: response written here, filled = 1.
  - rd_ptr: head.
- occupancy = alloc - rd, width $clog2(FIFO_DEPTH)+1.
- Request issue:
  - imem_req_valid = !redirect_valid && occupancy < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 4 with wrap-around; alloc_ptr++.
  - Request stays asserted with a stable address until accepted.
- Response: if drop_cnt != 0, discard the response and decrement drop_cnt; otherwise fill the slot at fill_ptr and increment fill_ptr.
- Output:
  - out_valid = head slot filled && !redirect_valid; fields come directly from the head slot.
  - Fire (valid && ready): clear filled, rd_ptr++.
  - A slot frees in the same cycle it is popped; the freed space is visible to the issue check next cycle.
- Latency:
  - First request is asserted the first cycle after reset release.
  - With zero-wait memory (response one cycle after accept), out_valid rises 2 cycles after request accept.
  - Sustained throughput: 1 instruction/cycle when out_ready and imem_req_ready stay high.
- Redirect (cycle with redirect_valid = 1):
  - No request is issued and no output fires.
  - Next state: fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}; all pointers = 0; all filled = 0.
  - drop_cnt = (alloc - fill) - (resp arriving this cycle && drop_cnt == 0) + drop_cnt - (resp arriving && drop_cnt != 0). Net effect: every request accepted before the redirect whose response is not yet consumed gets dropped.
  - Back-to-back redirects: the last one wins; drop_cnt keeps accumulating.
  - Redirect during reset has no effect.
- Full: occupancy == FIFO_DEPTH keeps imem_req_valid = 0 until a pop.
- Empty or head unfilled: out_valid = 0; decode sees a bubble.
- The ordering invariant (responses in request order) is a memory requirement and is not checked.
- Assertions:
  - drop_cnt + occupancy <= 2*FIFO_DEPTH.
  - A response with drop_cnt == 0 and fill == alloc is illegal.

Decomposition:
- fetch_pkg: XLEN, RESET_PC default, INSTR_BYTES = 4, the fetch bundle struct {pc, instr, pc_plus_four}, and a ptr_t width function.
- Sub-module fetch_slot_queue: three-pointer reserve/fill/pop storage with occupancy and flush.
- Top level: PC register, request control, drop counter, redirect muxing.

Test Plan:
- Reset release, zero-wait imem, out_ready = 1 -> requests issued to 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; out_pc 0x00400000 two cycles after the first accept, then one bundle per cycle with out_pc_plus_four = out_pc + 4.
- out_ready = 0 for 10 cycles, FIFO_DEPTH = 4 -> exactly 4 requests accepted, imem_req_valid drops; 4 bundles drain in order on release.
- imem_req_ready = 0 for 3 cycles -> imem_req_addr held at 0x00400004 and stable; no PC skip.
- Memory latency 3 cycles with 3 outstanding, redirect_pc = 0x00400102 -> next request addr 0x00400100; 3 stale responses dropped; first out_pc = 0x00400100.
- Redirect in the same cycle as a response and an out handshake -> no bundle is consumed, the response is dropped, and drop_cnt is correct; redirects on two consecutive cycles -> the second target is fetched.
- fetch_pc = 0xFFFFFFFC -> next request 0x00000000 and out_pc_plus_four = 0x00000000; rst_n asserted mid-stream -> all outputs return to reset values immediately, and the first post-reset request is RESET_PC.
